// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding,
// default widths and the read-latency counter width.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    localparam int DEF_NUM_CORES = 4;
    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_RD_LAT    = 1;

    // RD_LAT is at most 4, so the count never exceeds 3
    localparam int LAT_CNT_W = 3;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dm_arbiter_rr_picker.sv
// Combinational rotating-priority picker: the first asserted request
// at or after base (wrapping modulo N) wins.
module rr_picker
    import dm_arb_pkg::*;
#(
    parameter int N  = DEF_NUM_CORES,
    parameter int IW = idx_w(DEF_NUM_CORES)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] base,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0]   sum;
    logic [IW-1:0] pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        sum    = '0;
        pos    = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, base} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            pos = sum[IW-1:0];
            if (!any && req[pos]) begin
                any         = 1'b1;
                idx         = pos;
                onehot[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter giving NUM_CORES cores access to one DM port.
// Define DM_ARB_FIXED_PRIO_EN for fixed (lowest index) priority.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RD_LAT    = DEF_RD_LAT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
    output logic [NUM_CORES-1:0]        gnt,
    output logic [NUM_CORES-1:0]        done,
    output logic [DATA_W-1:0]           rdata,
    output logic                        dm_en,
    output logic                        dm_we,
    output logic [ADDR_W-1:0]           dm_addr,
    output logic [DATA_W-1:0]           dm_wdata,
    input  logic [DATA_W-1:0]           dm_rdata
);

    localparam int IW = idx_w(NUM_CORES);

    arb_state_e             state;
    arb_state_e             state_nx;
    logic [NUM_CORES-1:0]   gnt_q;
    logic                   lat_we;
    logic [LAT_CNT_W-1:0]   cnt;

    logic [IW-1:0]          base;
    logic [NUM_CORES-1:0]   pick_oh;
    logic [IW-1:0]          pick_idx;
    logic                   pick_any;

    logic                   sel_we;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_wdata;

`ifdef DM_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [IW-1:0] ptr;

    assign base = ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (state == IDLE && pick_any) begin
            if (pick_idx == IW'(NUM_CORES - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= pick_idx + 1'b1;
            end
        end
    end
`endif

    rr_picker #(
        .N  (NUM_CORES),
        .IW (IW)
    ) u_picker (
        .req    (req),
        .base   (base),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (pick_oh[i]) begin
                sel_we    = we[i];
                sel_addr  = addr[i*ADDR_W +: ADDR_W];
                sel_wdata = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_any) state_nx = ACCESS;
            ACCESS:  state_nx = lat_we ? RESP : WAIT;
            WAIT:    if (cnt == LAT_CNT_W'(RD_LAT - 1)) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt_q    <= '0;
            lat_we   <= 1'b0;
            cnt      <= '0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            rdata    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && pick_any) begin
                gnt_q    <= pick_oh;
                lat_we   <= sel_we;
                dm_addr  <= sel_addr;
                dm_wdata <= sel_wdata;
            end
            if (state == RESP) begin
                gnt_q <= '0;
            end
            if (state == ACCESS) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + 1'b1;
            end
            // capture in the last WAIT cycle, when DM data is valid
            if (state == WAIT && state_nx == RESP) begin
                rdata <= dm_rdata;
            end
        end
    end

    assign gnt   = gnt_q;
    assign done  = (state == RESP) ? gnt_q : '0;
    assign dm_en = (state == ACCESS);
    assign dm_we = (state == ACCESS) && lat_we;

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized self-checking bench for dm_arbiter with a DM model and
// a transaction-level reference of arbitration and memory contents.
module tb_dm_arbiter;

    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    we = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [DW-1:0]   rdata;
    logic            dm_en;
    logic            dm_we;
    logic [AW-1:0]   dm_addr;
    logic [DW-1:0]   dm_wdata;
    logic [DW-1:0]   dm_rdata;

    int total = 0;
    int bad = 0;

    dm_arbiter #(
        .NUM_CORES (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .RD_LAT    (LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .done     (done),
        .rdata    (rdata),
        .dm_en    (dm_en),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata)
    );

    always #5 clk = ~clk;

    // DM model: synchronous write, read data delayed LAT cycles
    logic [DW-1:0] dm_mem [64];
    logic [DW-1:0] rd_pipe [LAT];

    always @(posedge clk) begin
        if (dm_en && dm_we) dm_mem[dm_addr[5:0]] <= dm_wdata;
        rd_pipe[0] <= dm_mem[dm_addr[5:0]];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign dm_rdata = rd_pipe[LAT-1];

    // reference state
    logic [DW-1:0] ref_mem [64];
    int            ptr_m = 0;
    logic [DW-1:0] rdata_m = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int pick(input logic [N-1:0] m);
        int c;
        for (int k = 0; k < N; k++) begin
`ifdef DM_ARB_FIXED_PRIO_EN
            c = k;
`else
            c = (ptr_m + k) % N;
`endif
            if (m[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_core(input int c, input logic w,
                            input logic [15:0] a, input logic [15:0] d);
        req[c] = 1'b1;
        we[c] = w;
        addr[c*AW +: AW] = a;
        wdata[c*DW +: DW] = d;
    endtask

    // Called at a negedge while the DUT is idle; runs one transaction
    task automatic run_tx(input int perturb);
        int            w;
        logic          e_we;
        logic [15:0]   e_a;
        logic [15:0]   e_d;
        logic [15:0]   e_r;
        logic [N-1:0]  e_g;
        chk("idle_gnt", 32'(gnt), 0);
        chk("idle_done", 32'(done), 0);
        chk("idle_en", 32'(dm_en), 0);
        w = pick(req);
        if (w < 0) begin
            tick();
            return;
        end
        ptr_m = (w + 1) % N;
        e_g = '0;
        e_g[w] = 1'b1;
        e_we = we[w];
        e_a = addr[w*AW +: AW];
        e_d = wdata[w*DW +: DW];
        e_r = rdata_m;
        tick();
        chk("acc_gnt", 32'(gnt), 32'(e_g));
        chk("acc_en", 32'(dm_en), 1);
        chk("acc_we", 32'(dm_we), 32'(e_we));
        chk("acc_addr", 32'(dm_addr), 32'(e_a));
        if (e_we) chk("acc_wdata", 32'(dm_wdata), 32'(e_d));
        chk("acc_done", 32'(done), 0);
        if (perturb == 1) begin
            addr[w*AW +: AW] = 16'($urandom_range(0, 15));
            wdata[w*DW +: DW] = 16'($urandom);
            if ($urandom_range(0, 3) == 0) req[w] = 1'b0;
        end else if (perturb == 2) begin
            addr[w*AW +: AW] = 16'h0033;
            req[w] = 1'b0;
        end
        if (e_we) ref_mem[e_a[5:0]] = e_d;
        else e_r = ref_mem[e_a[5:0]];
        if (!e_we) begin
            repeat (LAT) begin
                tick();
                chk("wait_gnt", 32'(gnt), 32'(e_g));
                chk("wait_en", 32'(dm_en), 0);
                chk("wait_done", 32'(done), 0);
                chk("wait_addr", 32'(dm_addr), 32'(e_a));
            end
        end
        tick();
        chk("resp_done", 32'(done), 32'(e_g));
        chk("resp_gnt", 32'(gnt), 32'(e_g));
        chk("resp_en", 32'(dm_en), 0);
        chk("resp_we", 32'(dm_we), 0);
        rdata_m = e_r;
        chk("resp_rdata", 32'(rdata), 32'(rdata_m));
        req[w] = 1'b0;
        tick();
    endtask

    initial begin
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_en", 32'(dm_en), 0);
        chk("rst_addr", 32'(dm_addr), 0);
        chk("rst_rdata", 32'(rdata), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        set_core(2, 1'b1, 16'h0010, 16'hBEEF);
        run_tx(0);
        set_core(3, 1'b1, 16'h0020, 16'h1234);
        run_tx(0);
        set_core(0, 1'b0, 16'h0020, 16'h0000);
        run_tx(0);
        set_core(2, 1'b1, 16'h0021, 16'h5555);
        run_tx(0);
        set_core(0, 1'b1, 16'h0022, 16'h0A0A);
        set_core(2, 1'b0, 16'h0010, 16'h0000);
        run_tx(0);
        run_tx(0);
        set_core(1, 1'b0, 16'h0010, 16'h0000);
        run_tx(2);

        for (int i = 0; i < 16; i++) begin
            set_core(i % N, 1'b1, 16'(i), 16'($urandom));
            run_tx(0);
        end

        for (int r = 0; r < 300; r++) begin
            for (int c = 0; c < N; c++) begin
                if (!req[c] && $urandom_range(0, 1) == 1) begin
                    set_core(c, 1'($urandom_range(0, 1)),
                             16'($urandom_range(0, 15)), 16'($urandom));
                end
            end
            run_tx(1);
        end

        req = '0;
        set_core(1, 1'b0, 16'h0005, 16'h0000);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_en", 32'(dm_en), 0);
        chk("mid_rst_addr", 32'(dm_addr), 0);
        chk("mid_rst_wdata", 32'(dm_wdata), 0);
        chk("mid_rst_rdata", 32'(rdata), 0);
        req = '0;
        ptr_m = 0;
        rdata_m = '0;
        repeat (3) begin
            tick();
            chk("in_rst_done", 32'(done), 0);
        end
        for (int c = 0; c < N; c++) set_core(c, 1'b0, 16'(c), 16'h0000);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) run_tx(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Shared data-memory arbiter that lets up to NUM_CORES processor cores reach one single-port data memory (DM). Each core's control unit raises a request instead of driving DM directly. The arbiter grants one core at a time in round-robin order, sequences the DM access (write, or read with fixed latency), and returns a one-cycle done pulse with read data. It sits between the cores' DM bus ports and the DM instance.

## Interface
- NUM_CORES, 4: number of requesting cores (2..8).
- ADDR_W, 16: DM address width.
- DATA_W, 16: DM data width.
- RD_LAT, 1: DM read latency in cycles, from the dm_en cycle to dm_rdata valid (1..4).

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_CORES  per-core access request; level, held until done.
- we  in  NUM_CORES  per-core write(1)/read(0); stable while req is high.
- addr  in  NUM_CORES*ADDR_W  per-core address, packed; core i occupies [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_CORES*DATA_W  per-core write data, packed in the same way.
- gnt  out  NUM_CORES  one-hot; marks the core owning the current transaction.
- done  out  NUM_CORES  one-cycle completion pulse to the granted core.
- rdata  out  DATA_W  read data; valid in the done cycle of a read.
- dm_en  out  1  DM access strobe.
- dm_we  out  1  DM write enable; qualified by dm_en.
- dm_addr  out  ADDR_W  DM address.
- dm_wdata  out  DATA_W  DM write data.
- dm_rdata  in  DATA_W  DM read data.

## Operation
- The FSM has four states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If any req is high, pick a winner, latch its we/addr/wdata, set gnt to the winner's one-hot and go to ACCESS.
  - Otherwise stay in IDLE with gnt=0.
- ACCESS:
  - Drive dm_en=1, dm_we=latched we, dm_addr and dm_wdata from the latched values. This lasts one cycle.
  - A write goes next to RESP.
  - A read goes next to WAIT.
- WAIT:
  - Count RD_LAT cycles.
  - In the last WAIT cycle, register dm_rdata into rdata, then go to RESP.
- RESP:
  - done[winner]=1 for one cycle, then return to IDLE. gnt clears on entry to IDLE.
- Arbitration is round-robin:
  - The search starts at ptr and wraps modulo NUM_CORES; the first asserted req wins.
  - On each grant, ptr = winner+1 (wrapping to 0 after NUM_CORES-1).
- Requester rule: req drops at the edge that ends its done cycle. If req is still high in the following IDLE cycle, it is treated as a new request.
- If req is withdrawn during ACCESS/WAIT, the latched transaction still completes and done still pulses.
- Changes to we/addr/wdata after grant are ignored, because the values were latched.
- rdata holds its last read value until the next read completes. Writes do not change it.
- Outside ACCESS: dm_en=0 and dm_we=0. dm_addr and dm_wdata hold the latched values.

## Timing
- Reset (rst_n low, any state): state=IDLE, ptr=0, gnt=0, done=0, dm_en=0, dm_we=0, dm_addr=0, dm_wdata=0, rdata=0.
  - Reset during a transaction abandons it; no done is issued.
- Write with req seen in IDLE at cycle 0: ACCESS at cycle 1 (dm_en, dm_we high), done at cycle 2, IDLE at cycle 3. That is 3 cycles per write.
- Read: ACCESS at cycle 1, WAIT for cycles 2..1+RD_LAT, done at cycle 2+RD_LAT. That is 3+RD_LAT cycles per read (4 with RD_LAT=1).
- gnt is high from cycle 1 through the done cycle inclusive.
- Simultaneous requests: exactly one grant per transaction. No core waits more than NUM_CORES-1 transactions.
- All outputs are registered or decoded from the registered state only. There is no combinational path from req to gnt.

## Configuration
- DM_ARB_FIXED_PRIO_EN:
  - When defined, arbitration is fixed priority (lowest asserted index wins) and ptr is removed. Intended for single-core debug builds where deterministic ordering matters.
  - When undefined (default), arbitration is round-robin as described above.
- The FSM and timing are identical in both builds.

## Structure
- Package dm_arb_pkg holds:
  - the FSM state encoding (IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, RESP=2'd3);
  - default width constants;
  - the RD_LAT counter width.
- Sub-module rr_picker: a combinational rotating-priority picker.
  - Inputs: req, base. Outputs: one-hot winner, winner index, any.
  - With DM_ARB_FIXED_PRIO_EN, base is tied to 0.

## Test plan
- Single write: core 2 sends we=1, addr=0x0010, wdata=0xBEEF.
  - Expect dm_en=dm_we=1 with 0x0010/0xBEEF at cycle 1, done[2] at cycle 2, gnt=4'b0100 over cycles 1–2.
- Single read with RD_LAT=1: DM returns 0x1234 at addr 0x0020; core 0 reads it.
  - Expect done[0] at cycle 3 with rdata=0x1234, and dm_we=0 throughout.
- Round-robin fairness: all 4 cores assert read continuously, re-requesting after each done.
  - Expect grant order 0,1,2,3,0,1. With DM_ARB_FIXED_PRIO_EN, expect 0,0,0,….
- Wrap and skip: ptr=3 and req=4'b0101. Expect core 0 granted, then core 2, then ptr=3.
- Withdrawal: core 1 drops req and changes addr during ACCESS. Expect the original access on DM and done[1] still pulsed.
- Reset mid-read: assert rst_n low during WAIT.
  - Expect all outputs at reset values immediately (asynchronous) and no done.
  - After release, a new request is granted normally starting from core 0.
